// File: rtl/mem_router_if.sv
// Bus bundle between the CPU load/store port, the mem_router and its two targets.
// master = CPU plus target models; slave = the router itself.
interface mem_router_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_AW  = 16,
    parameter int PERI_AW = 14
) ();
    // CPU side: the CPU holds address/data/re/we steady while mem_busy is 1.
    // mem_busy falls for exactly the one DONE cycle that carries read_data and bus_err.
    // Target side: a strobe (re/we) stays high until the target returns ready=1.
    // rdata is sampled on the same edge as ready.
    logic [ADDR_W-1:0]  address;
    logic [DATA_W-1:0]  write_data;
    logic               we;
    logic               re;
    logic [DATA_W-1:0]  read_data;
    logic               mem_busy;
    logic               bus_err;

    logic               ram_re;
    logic               ram_we;
    logic [RAM_AW-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic               ram_ready;

    logic               peri_re;
    logic               peri_we;
    logic [PERI_AW-1:0] peri_addr;
    logic [DATA_W-1:0]  peri_wdata;
    logic [DATA_W-1:0]  peri_rdata;
    logic               peri_ready;

    modport master (
        output address, write_data, we, re,
        input  read_data, mem_busy, bus_err,
        input  ram_re, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ready,
        input  peri_re, peri_we, peri_addr, peri_wdata,
        output peri_rdata, peri_ready
    );

    modport slave (
        input  address, write_data, we, re,
        output read_data, mem_busy, bus_err,
        output ram_re, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ready,
        output peri_re, peri_we, peri_addr, peri_wdata,
        input  peri_rdata, peri_ready
    );
endinterface

// File: rtl/mem_router.sv
// Routes one CPU load/store at a time to the RAM controller or the peripheral bus.
// Unmapped accesses and target timeouts complete with bus_err.
module mem_router #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE = 'h0000_4000,
    parameter int                RAM_AW   = 16,
    parameter int                PERI_AW  = 14,
    parameter int                TO_W     = 8,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    mem_router_if.slave bus,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_ACC  = 2'd1,
        PERI_ACC = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Window limits are one bit wider than the address so that the RAM end never wraps.
    localparam logic [ADDR_W:0] RAM_LO    = {1'b0, RAM_BASE};
    localparam logic [ADDR_W:0] RAM_HI    = RAM_LO + ((ADDR_W+1)'(1) << RAM_AW);
    localparam logic [ADDR_W:0] PERI_SPAN = (ADDR_W+1)'(1) << PERI_AW;
    localparam logic [ADDR_W:0] PERI_HI   = (PERI_SPAN < RAM_LO) ? PERI_SPAN : RAM_LO;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [PERI_AW-1:0]  peri_addr_q, peri_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [ADDR_W:0]     addr_ext;
    logic                hit_peri;
    logic                hit_ram;
    logic                req;
    logic                tgt_ready;
    logic [DATA_W-1:0]   tgt_rdata;

    assign addr_ext = {1'b0, bus.address};
    assign hit_peri = (addr_ext < PERI_HI);
    assign hit_ram  = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
    assign req      = bus.re | bus.we;

    assign tgt_ready = (state_q == RAM_ACC) ? bus.ram_ready : bus.peri_ready;
    assign tgt_rdata = (state_q == RAM_ACC) ? bus.ram_rdata : bus.peri_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            peri_addr_q <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            peri_addr_q <= peri_addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        peri_addr_d = peri_addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d        = bus.we;
                    wdata_d     = bus.write_data;
                    ram_addr_d  = RAM_AW'(bus.address - RAM_BASE);
                    peri_addr_d = PERI_AW'(bus.address);
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    if (hit_peri) begin
                        state_d = PERI_ACC;
                    end else if (hit_ram) begin
                        state_d = RAM_ACC;
                    end else begin
                        // Unmapped: finish straight away without touching either target.
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            RAM_ACC, PERI_ACC: begin
                cnt_d = cnt_q + 1'b1;
                if (tgt_ready) begin
                    if (!wr_q) rdata_d = tgt_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    if (!wr_q) rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode only registered state, so they ignore the live CPU inputs.
    assign bus.ram_re     = (state_q == RAM_ACC)  && !wr_q;
    assign bus.ram_we     = (state_q == RAM_ACC)  &&  wr_q;
    assign bus.peri_re    = (state_q == PERI_ACC) && !wr_q;
    assign bus.peri_we    = (state_q == PERI_ACC) &&  wr_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.peri_addr  = peri_addr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.peri_wdata = wdata_q;

    assign bus.read_data = rdata_q;
    assign bus.bus_err   = err_q;
    assign bus.mem_busy  = (state_q == RAM_ACC) || (state_q == PERI_ACC) ||
                           ((state_q == IDLE) && req);

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: decode, target handshakes, timeout, priority and async reset.
module tb_mem_router;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAM  = 2'd1;
  localparam logic [1:0] S_PERI = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;
  int         hi_cnt;

  mem_router_if #(.ADDR_W(32), .DATA_W(32), .RAM_AW(16), .PERI_AW(14)) bus ();

  mem_router dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit expired, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_req(input logic [31:0] addr, input logic [31:0] data,
                         input logic r, input logic w);
    bus.address    = addr;
    bus.write_data = data;
    bus.re         = r;
    bus.we         = w;
  endtask

  task automatic cpu_idle();
    bus.re = 1'b0;
    bus.we = 1'b0;
  endtask

  // At most one target strobe may be high in any cycle.
  always @(negedge clk) begin
    n_vec++;
    assert ($countones({bus.ram_re, bus.ram_we, bus.peri_re, bus.peri_we}) <= 1) else begin
      n_err++;
      $error("FAIL strobe_excl: observed %b expected at most one hot",
             {bus.ram_re, bus.ram_we, bus.peri_re, bus.peri_we});
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    cpu_req(32'h0, 32'h0, 1'b0, 1'b0);
    bus.ram_rdata  = '0;
    bus.ram_ready  = 1'b0;
    bus.peri_rdata = '0;
    bus.peri_ready = 1'b0;
    tick();
    tick();
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_rdata", bus.read_data, 32'h0);
    chk("rst_err", bus.bus_err, 1'b0);
    chk("rst_busy", bus.mem_busy, 1'b0);
    chk("rst_addr", bus.ram_addr, 32'h0);
    rst = 1'b0;
    tick();

    // RAM read, ready on the third strobe cycle
    cpu_req(32'h0000_4010, 32'h0, 1'b1, 1'b0);
    #1;
    chk("ram_rd_busy_idle", bus.mem_busy, 1'b1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      chk("ram_rd_strobe", bus.ram_re, 1'b1);
      chk("ram_rd_busy", bus.mem_busy, 1'b1);
      chk("ram_rd_addr", bus.ram_addr, 32'h0010);
      if (i == 3) begin
        bus.ram_ready = 1'b1;
        bus.ram_rdata = 32'h1234_5678;
      end
      tick();
    end
    chk("ram_rd_done", dbg_state, S_DONE);
    chk("ram_rd_strobe_off", bus.ram_re, 1'b0);
    chk("ram_rd_data", bus.read_data, 32'h1234_5678);
    chk("ram_rd_err", bus.bus_err, 1'b0);
    chk("ram_rd_busy_done", bus.mem_busy, 1'b0);
    cpu_idle();
    bus.ram_ready = 1'b0;
    tick();
    chk("ram_rd_back_idle", dbg_state, S_IDLE);

    // peripheral write, ready tied high
    bus.peri_ready = 1'b1;
    cpu_req(32'h0000_0024, 32'h0000_00A5, 1'b0, 1'b1);
    tick();
    chk("peri_wr_state", dbg_state, S_PERI);
    chk("peri_wr_strobe", bus.peri_we, 1'b1);
    chk("peri_wr_addr", bus.peri_addr, 32'h0024);
    chk("peri_wr_data", bus.peri_wdata, 32'h0000_00A5);
    chk("peri_wr_no_ram", {bus.ram_re, bus.ram_we}, 2'b00);
    tick();
    chk("peri_wr_done", dbg_state, S_DONE);
    chk("peri_wr_strobe_off", bus.peri_we, 1'b0);
    chk("peri_wr_rdata_kept", bus.read_data, 32'h1234_5678);
    chk("peri_wr_err", bus.bus_err, 1'b0);
    cpu_idle();
    bus.peri_ready = 1'b0;
    tick();

    // unmapped read above the RAM window
    cpu_req(32'h0002_0000, 32'h0, 1'b1, 1'b0);
    #1;
    chk("unmap_busy_idle", bus.mem_busy, 1'b1);
    tick();
    chk("unmap_done", dbg_state, S_DONE);
    chk("unmap_err", bus.bus_err, 1'b1);
    chk("unmap_data", bus.read_data, 32'hDEAD_BEEF);
    chk("unmap_no_strobe", {bus.ram_re, bus.ram_we, bus.peri_re, bus.peri_we}, 4'b0);
    cpu_idle();
    tick();
    chk("unmap_err_clear", bus.bus_err, 1'b0);

    // window boundaries
    cpu_req(32'h0000_3FFF, 32'h0, 1'b1, 1'b0);
    tick();
    chk("edge_peri_top", dbg_state, S_PERI);
    chk("edge_peri_addr", bus.peri_addr, 32'h3FFF);
    rst = 1'b1;
    cpu_idle();
    #1;
    rst = 1'b0;
    cpu_req(32'h0001_3FFF, 32'h0, 1'b1, 1'b0);
    tick();
    chk("edge_ram_top", dbg_state, S_RAM);
    chk("edge_ram_addr", bus.ram_addr, 32'hFFFF);
    rst = 1'b1;
    cpu_idle();
    #1;
    rst = 1'b0;
    cpu_req(32'h0001_4000, 32'h0, 1'b0, 1'b1);
    tick();
    chk("edge_ram_end", dbg_state, S_DONE);
    chk("edge_ram_end_err", bus.bus_err, 1'b1);
    cpu_idle();
    tick();

    // RAM read timing out
    cpu_req(32'h0000_4000, 32'h0, 1'b1, 1'b0);
    tick();
    hi_cnt = 0;
    while (bus.ram_re === 1'b1 && hi_cnt < 300) begin
      hi_cnt++;
      tick();
    end
    chk("to_strobe_cycles", hi_cnt, 255);
    chk("to_done", dbg_state, S_DONE);
    chk("to_err", bus.bus_err, 1'b1);
    chk("to_data", bus.read_data, 32'hDEAD_BEEF);
    cpu_idle();
    tick();

    // ready arriving on the last permitted cycle wins
    cpu_req(32'h0000_4000, 32'h0, 1'b1, 1'b0);
    tick();
    for (int i = 1; i < 255; i++) tick();
    chk("to_last_strobe", bus.ram_re, 1'b1);
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'hCAFE_F00D;
    tick();
    chk("to_last_done", dbg_state, S_DONE);
    chk("to_last_err", bus.bus_err, 1'b0);
    chk("to_last_data", bus.read_data, 32'hCAFE_F00D);
    cpu_idle();
    bus.ram_ready = 1'b0;
    tick();

    // re and we together: write wins
    bus.ram_ready = 1'b1;
    cpu_req(32'h0000_4000, 32'h0000_0011, 1'b1, 1'b1);
    tick();
    chk("both_strobes", {bus.ram_re, bus.ram_we}, 2'b01);
    chk("both_wdata", bus.ram_wdata, 32'h0000_0011);
    tick();
    chk("both_done", dbg_state, S_DONE);
    chk("both_rdata_kept", bus.read_data, 32'hCAFE_F00D);
    chk("both_err", bus.bus_err, 1'b0);
    cpu_idle();
    bus.ram_ready = 1'b0;
    tick();

    // async reset in the middle of a RAM access
    cpu_req(32'h0000_4010, 32'h0, 1'b1, 1'b0);
    tick();
    chk("arst_pre_strobe", bus.ram_re, 1'b1);
    #2;
    rst = 1'b1;
    cpu_idle();
    #1;
    chk("arst_strobe", bus.ram_re, 1'b0);
    chk("arst_rdata", bus.read_data, 32'h0);
    chk("arst_busy", bus.mem_busy, 1'b0);
    chk("arst_state", dbg_state, S_IDLE);
    tick();
    rst = 1'b0;
    tick();

    // fresh peripheral read after reset
    cpu_req(32'h0000_0100, 32'h0, 1'b1, 1'b0);
    tick();
    chk("post_peri_strobe", bus.peri_re, 1'b1);
    chk("post_peri_addr", bus.peri_addr, 32'h0100);
    bus.peri_ready = 1'b1;
    bus.peri_rdata = 32'h0BAD_F00D;
    tick();
    chk("post_peri_done", dbg_state, S_DONE);
    chk("post_peri_data", bus.read_data, 32'h0BAD_F00D);
    chk("post_peri_err", bus.bus_err, 1'b0);
    cpu_idle();
    bus.peri_ready = 1'b0;
    tick();
    chk("post_peri_idle", dbg_state, S_IDLE);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
